fp_mul_pipe: RTL and testbench

// - Pipelined, parametrised IEEE-754 binary floating-point multiplier. It is the

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_unpack.sv | 38 +++
 rtl/fp_mul_pipe.sv | 185 ++++++++++++++++++
 tb/tb_fp_mul_pipe.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared types and helpers for the pipelined floating-point multiplier:
// operand classes, flag bit positions, exponent bias and canonical quiet NaN.
package fp_pkg;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_NORM,
    FP_INF,
    FP_QNAN,
    FP_SNAN
  } fp_class_e;

  localparam int FLG_INV = 3;
  localparam int FLG_OVF = 2;
  localparam int FLG_UNF = 1;
  localparam int FLG_INX = 0;

  // Widest format the helpers can describe; callers slice down to their width.
  localparam int FP_MAX_W = 128;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  function automatic logic [FP_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
    logic [FP_MAX_W-1:0] one;
    one = FP_MAX_W'(1);
    return (((one << exp_w) - one) << man_w) | (one << (man_w - 1));
  endfunction

endpackage

// File: rtl/fp_unpack.sv
// Splits an IEEE-754 operand into sign, exponent and mantissa with hidden bit,
// and classifies it. Subnormals report as zero so they flush downstream.
module fp_unpack
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sign,
  output logic [EXP_W-1:0]     exp_f,
  output logic [MAN_W:0]       mant,
  output fp_class_e            cls
);

  logic [MAN_W-1:0] frac;

  assign sign  = op[EXP_W+MAN_W];
  assign exp_f = op[EXP_W+MAN_W-1:MAN_W];
  assign frac  = op[MAN_W-1:0];
  assign mant  = {1'b1, frac};

  always_comb begin
    cls = FP_NORM;
    if (exp_f == '0) begin
      cls = FP_ZERO;
    end else if (&exp_f) begin
      if (frac == '0) begin
        cls = FP_INF;
      end else if (frac[MAN_W-1]) begin
        cls = FP_QNAN;
      end else begin
        cls = FP_SNAN;
      end
    end
  end

endmodule

// File: rtl/fp_mul_pipe.sv
// Three-stage IEEE-754 multiplier (unpack, multiply, normalise/round/pack)
// with a valid/ready stream interface; a stalled output freezes every stage.
module fp_mul_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic [EXP_W+MAN_W:0] in2,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [3:0]           flags
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int ESW = EXP_W + 2;
  localparam int PW  = 2 * MAN_W + 2;

  localparam logic [ESW-1:0] BIAS  = ESW'(fp_bias(EXP_W));
  localparam logic [ESW-1:0] E_MAX = ESW'((1 << EXP_W) - 1);
  localparam logic [W-1:0]   QNAN  = W'(fp_qnan(EXP_W, MAN_W));

  logic adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 1: unpack and classify
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W:0]   ma, mb;
  fp_class_e        ca, cb;
  logic [ESW-1:0]   esum_c;

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_a (
    .op    (in1),
    .sign  (sa),
    .exp_f (ea),
    .mant  (ma),
    .cls   (ca)
  );

  fp_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack_b (
    .op    (in2),
    .sign  (sb),
    .exp_f (eb),
    .mant  (mb),
    .cls   (cb)
  );

  // Two's-complement in ESW bits; negative sums appear with the top bit set.
  assign esum_c = {2'b00, ea} + {2'b00, eb} - BIAS;

  logic           v1, sign1;
  logic [ESW-1:0] esum1;
  logic [MAN_W:0] ma1, mb1;
  fp_class_e      ca1, cb1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      sign1 <= 1'b0;
      esum1 <= '0;
      ma1   <= '0;
      mb1   <= '0;
      ca1   <= FP_ZERO;
      cb1   <= FP_ZERO;
    end else if (adv) begin
      v1    <= in_valid;
      sign1 <= sa ^ sb;
      esum1 <= esum_c;
      ma1   <= ma;
      mb1   <= mb;
      ca1   <= ca;
      cb1   <= cb;
    end
  end

  // Stage 2: full-width mantissa product
  logic           v2, sign2;
  logic [ESW-1:0] esum2;
  logic [PW-1:0]  prod2;
  fp_class_e      ca2, cb2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2    <= 1'b0;
      sign2 <= 1'b0;
      esum2 <= '0;
      prod2 <= '0;
      ca2   <= FP_ZERO;
      cb2   <= FP_ZERO;
    end else if (adv) begin
      v2    <= v1;
      sign2 <= sign1;
      esum2 <= esum1;
      prod2 <= {{(MAN_W+1){1'b0}}, ma1} * {{(MAN_W+1){1'b0}}, mb1};
      ca2   <= ca1;
      cb2   <= cb1;
    end
  end

  // Stage 3: normalise, round to nearest even, range check, special cases
  logic [PW-2:0]  norm;
  logic [MAN_W-1:0] frac_t;
  logic           guard, sticky, rnd_up;
  logic [MAN_W:0] frac_r;
  logic [ESW-1:0] e_norm, e_fin;
  logic           ovf, unf;
  logic           nan_a, nan_b, snan_any, inf_a, inf_b, zero_a, zero_b;
  logic [W-1:0]   res;
  logic [3:0]     flg;

  always_comb begin
    // After this, the leading one sits just above norm's top bit.
    norm   = prod2[PW-1] ? prod2[PW-2:0] : {prod2[PW-3:0], 1'b0};
    e_norm = esum2 + {{(ESW-1){1'b0}}, prod2[PW-1]};
    frac_t = norm[PW-2 -: MAN_W];
    guard  = norm[PW-2-MAN_W];
    sticky = |norm[PW-3-MAN_W:0];
    rnd_up = guard && (sticky || frac_t[0]);
    frac_r = {1'b0, frac_t} + {{MAN_W{1'b0}}, rnd_up};
    // A carry out of rounding leaves the fraction all-zero, so only the exponent moves.
    e_fin  = e_norm + {{(ESW-1){1'b0}}, frac_r[MAN_W]};
    ovf    = !e_fin[ESW-1] && (e_fin >= E_MAX);
    unf    = e_fin[ESW-1] || (e_fin == '0);

    nan_a    = (ca2 == FP_QNAN) || (ca2 == FP_SNAN);
    nan_b    = (cb2 == FP_QNAN) || (cb2 == FP_SNAN);
    snan_any = (ca2 == FP_SNAN) || (cb2 == FP_SNAN);
    inf_a    = (ca2 == FP_INF);
    inf_b    = (cb2 == FP_INF);
    zero_a   = (ca2 == FP_ZERO);
    zero_b   = (cb2 == FP_ZERO);

    res          = {sign2, e_fin[EXP_W-1:0], frac_r[MAN_W-1:0]};
    flg          = '0;
    flg[FLG_INX] = guard | sticky;

    if (ovf) begin
      res          = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLG_OVF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end else if (unf) begin
      res          = {sign2, {(W-1){1'b0}}};
      flg[FLG_UNF] = 1'b1;
      flg[FLG_INX] = 1'b1;
    end

    if (nan_a || nan_b) begin
      res          = QNAN;
      flg          = '0;
      flg[FLG_INV] = snan_any;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      res          = QNAN;
      flg          = '0;
      flg[FLG_INV] = 1'b1;
    end else if (inf_a || inf_b) begin
      res = {sign2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg = '0;
    end else if (zero_a || zero_b) begin
      res = {sign2, {(W-1){1'b0}}};
      flg = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out       <= '0;
      flags     <= '0;
    end else if (adv) begin
      out_valid <= v2;
      out       <= res;
      flags     <= flg;
    end
  end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Scoreboard bench for fp_mul_pipe at single precision: known-answer vectors,
// latency, backpressure stall and reset flush.
module tb_fp_mul_pipe;

  localparam int W = 32;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in1 = '0;
  logic [W-1:0] in2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out;
  logic [3:0]   flags;

  logic [W+3:0] cur_exp = '0;
  logic [W+3:0] sb[$];
  vec_t         vecs[13];
  int           checks = 0;
  int           passed = 0;
  int           n_out = 0;

  always #5 clk = ~clk;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .flags     (flags)
  );

  task automatic drive(input vec_t v);
    int n;
    in1      = v.a;
    in2      = v.b;
    cur_exp  = {v.r, v.f};
    in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 50) begin
        checks++;
        $display("FAIL drive_timeout in_ready=%b required 1", in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b required 1", in_ready);
    else passed++;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b required 0", out_valid);
    else passed++;
    checks++;
    if (out !== '0) $display("FAIL rst_out got %h required 00000000", out);
    else passed++;
    checks++;
    if (flags !== 4'b0000) $display("FAIL rst_flags got %b required 0000", flags);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL post_rst_valid got %b required 0", out_valid);
    else passed++;
  endtask

  task automatic test_latency();
    drive(vecs[0]);
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_cycle1 out_valid=%b required 0", out_valid);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) $display("FAIL lat_cycle2 out_valid=%b required 0", out_valid);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out !== 32'h4000_0000 || flags !== 4'b0000)
      $display("FAIL lat_cycle3 out_valid=%b out=%h flags=%b required 1 40000000 0000",
               out_valid, out, flags);
    else passed++;
    wait_drain();
  endtask

  task automatic test_vectors();
    int base;
    base = n_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < 13; i++) drive(vecs[i]);
    in_valid = 1'b0;
    wait_drain();
    checks++;
    if (sb.size() != 0) $display("FAIL vec_pending got %0d required 0", sb.size());
    else passed++;
    checks++;
    if (n_out - base != 13) $display("FAIL vec_count got %0d required 13", n_out - base);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int          base;
    logic [31:0] held_o;
    logic [3:0]  held_f;
    base      = n_out;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 8; i++) drive(vecs[i]);
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        out_ready = 1'b0;
        held_o    = out;
        held_f    = flags;
        checks++;
        if (out_valid !== 1'b1) $display("FAIL stall_start out_valid=%b required 1", out_valid);
        else passed++;
        for (int k = 0; k < 4; k++) begin
          @(posedge clk);
          #1;
          checks++;
          if (out_valid !== 1'b1 || out !== held_o || flags !== held_f)
            $display("FAIL stall_hold cycle %0d got %b/%h/%b required 1/%h/%b",
                     k, out_valid, out, flags, held_o, held_f);
          else passed++;
          checks++;
          if (in_ready !== 1'b0) $display("FAIL stall_in_ready cycle %0d got %b required 0", k, in_ready);
          else passed++;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (sb.size() != 0) $display("FAIL b2b_pending got %0d required 0", sb.size());
    else passed++;
    checks++;
    if (n_out - base != 8) $display("FAIL b2b_count got %0d required 8", n_out - base);
    else passed++;
  endtask

  task automatic test_reset_flush();
    int base;
    @(posedge clk);
    #1;
    base = n_out;
    for (int i = 9; i < 12; i++) drive(vecs[i]);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (out_valid !== 1'b0) $display("FAIL flush_valid got %b required 0", out_valid);
    else passed++;
    checks++;
    if (in_ready !== 1'b1 || out !== '0 || flags !== 4'b0000)
      $display("FAIL flush_state in_ready=%b out=%h flags=%b required 1 00000000 0000",
               in_ready, out, flags);
    else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(vecs[1]);
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (n_out - base != 1) $display("FAIL flush_count got %0d required 1", n_out - base);
    else passed++;
    checks++;
    if (sb.size() != 0) $display("FAIL flush_pending got %0d required 0", sb.size());
    else passed++;
  endtask

  initial begin
    vecs[0]  = {32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 4'b0000};
    vecs[1]  = {32'h4020_0000, 32'h4060_0000, 32'h410C_0000, 4'b0000};
    vecs[2]  = {32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001};
    vecs[3]  = {32'hFF80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000};
    vecs[4]  = {32'hFF80_0000, 32'hFF80_0000, 32'h7F80_0000, 4'b0000};
    vecs[5]  = {32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000};
    vecs[6]  = {32'h7F00_0000, 32'h4000_0000, 32'h7F80_0000, 4'b0101};
    vecs[7]  = {32'h0080_0000, 32'h3F00_0000, 32'h0000_0000, 4'b0011};
    vecs[8]  = {32'h0000_0001, 32'h7F00_0000, 32'h0000_0000, 4'b0000};
    vecs[9]  = {32'h3FC0_0000, 32'h3F80_0005, 32'h3FC0_0008, 4'b0001};
    vecs[10] = {32'h3FC0_0000, 32'h3F80_0003, 32'h3FC0_0004, 4'b0001};
    vecs[11] = {32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 4'b0000};
    vecs[12] = {32'h7FC0_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b0000};

    fork
      forever begin
        logic [W+3:0] e;
        @(negedge clk);
        if (rst_n && in_valid && in_ready) sb.push_back(cur_exp);
        if (out_valid && out_ready) begin
          n_out++;
          checks++;
          if (sb.size() == 0) begin
            $display("FAIL sb_extra out=%h flags=%b with no result pending", out, flags);
          end else begin
            e = sb.pop_front();
            if ({out, flags} !== e)
              $display("FAIL sb_result got out=%h flags=%b required out=%h flags=%b",
                       out, flags, e[W+3:4], e[3:0]);
            else passed++;
          end
        end
      end
    join_none

    test_reset();
    test_latency();
    test_vectors();
    test_back_to_back();
    test_reset_flush();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
